// File: rtl/led_uart_tx.sv
// led_uart_tx: byte FIFO feeding an 8N1 UART transmitter.
// Bytes pushed by the ALU core's LED instruction are queued here and sent
// LSB first on oTx. Consecutive frames follow each other with no idle gap.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | line high, waiting for the FIFO to become non-empty
//   START | start bit (low) for one bit period
//   DATA  | eight data bits, LSB first, one bit period each
//   STOP  | stop bit (high); at its end, pop the next byte or go idle
module led_uart_tx #(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 4,
   parameter int FIFO_AW      = 2
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic               iWriteEnable,
   input  logic [7:0]         iData,
   output logic               oFull,
   output logic [FIFO_AW:0]   oCount,
   output logic               oTx,
   output logic               oBusy,
   output logic               oOverflow
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0]  BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [FIFO_AW:0]   FULL_COUNT = (FIFO_AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} txStateT;

   logic [7:0]          fifoMem [FIFO_DEPTH];
   logic [FIFO_AW-1:0]  wrPtr;
   logic [FIFO_AW-1:0]  rdPtr;
   logic [BAUD_W-1:0]   baudCnt;
   logic [2:0]          bitIdx;
   logic [7:0]          shiftReg;
   txStateT             state;
   logic                push;
   logic                pop;
   logic                baudDone;

   assign baudDone = (baudCnt == BAUD_LAST);
   // Fullness comes from the registered count, so a same-edge pop cannot
   // make room for a push that arrives while full.
   assign push     = iWriteEnable & ~oFull;
   assign pop      = (oCount != '0) & ((state == IDLE) | ((state == STOP) & baudDone));
   assign oFull    = (oCount == FULL_COUNT);
   assign oBusy    = (state != IDLE) | (oCount != '0);

   // FIFO storage; contents need no reset because occupancy is tracked separately
   always_ff @(posedge Clock) begin
      if (push) begin
         fifoMem[wrPtr] <= iData;
      end
   end

   // FIFO pointers, occupancy and the sticky overflow flag
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         wrPtr     <= '0;
         rdPtr     <= '0;
         oCount    <= '0;
         oOverflow <= 1'b0;
      end else begin
         if (push) begin
            wrPtr <= wrPtr + 1'b1;
         end
         if (pop) begin
            rdPtr <= rdPtr + 1'b1;
         end
         if (push && !pop) begin
            oCount <= oCount + 1'b1;
         end else if (pop && !push) begin
            oCount <= oCount - 1'b1;
         end
         if (iWriteEnable && oFull) begin
            oOverflow <= 1'b1;
         end
      end
   end

   // Transmit FSM: baud timing, bit sequencing and the registered TX line
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state    <= IDLE;
         baudCnt  <= '0;
         bitIdx   <= '0;
         shiftReg <= '0;
         oTx      <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               oTx <= 1'b1;
               if (pop) begin
                  shiftReg <= fifoMem[rdPtr];
                  baudCnt  <= '0;
                  state    <= START;
                  oTx      <= 1'b0;
               end
            end
            START: begin
               if (baudDone) begin
                  baudCnt <= '0;
                  bitIdx  <= '0;
                  state   <= DATA;
                  oTx     <= shiftReg[0];
               end else begin
                  baudCnt <= baudCnt + 1'b1;
               end
            end
            DATA: begin
               if (baudDone) begin
                  baudCnt <= '0;
                  if (bitIdx == 3'd7) begin
                     state <= STOP;
                     oTx   <= 1'b1;
                  end else begin
                     // shift right so the next bit to send is always in bit 1
                     bitIdx   <= bitIdx + 1'b1;
                     shiftReg <= {1'b0, shiftReg[7:1]};
                     oTx      <= shiftReg[1];
                  end
               end else begin
                  baudCnt <= baudCnt + 1'b1;
               end
            end
            STOP: begin
               if (baudDone) begin
                  baudCnt <= '0;
                  if (pop) begin
                     shiftReg <= fifoMem[rdPtr];
                     state    <= START;
                     oTx      <= 1'b0;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  baudCnt <= baudCnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               oTx   <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_led_uart_tx.sv
// tb_led_uart_tx: directed checks of led_uart_tx with short bit periods.
module tb_led_uart_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int AW    = 2;

   logic          Clock;
   logic          Reset;
   logic          iWriteEnable;
   logic [7:0]    iData;
   logic          oFull;
   logic [AW:0]   oCount;
   logic          oTx;
   logic          oBusy;
   logic          oOverflow;

   int nCompared   = 0;
   int nMismatched = 0;
   int peakCount   = 0;

   logic [7:0] ovfBytes [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

   led_uart_tx #(
      .CLKS_PER_BIT(CPB),
      .FIFO_DEPTH(DEPTH),
      .FIFO_AW(AW)
   ) dut (
      .Clock(Clock),
      .Reset(Reset),
      .iWriteEnable(iWriteEnable),
      .iData(iData),
      .oFull(oFull),
      .oCount(oCount),
      .oTx(oTx),
      .oBusy(oBusy),
      .oOverflow(oOverflow)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // track the highest FIFO occupancy seen within a test
   always @(negedge Clock) begin
      if (int'(oCount) > peakCount) peakCount = int'(oCount);
   end

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nCompared++;
      if (obs !== exp) begin
         nMismatched++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   // called 1ns after the edge at which the start bit appeared; returns 1ns after the frame's last edge
   task automatic checkFrame(input logic [7:0] b, input string tag);
      logic expBit;
      for (int c = 0; c < 10 * CPB; c++) begin
         int bitNo;
         bitNo = c / CPB;
         if (bitNo == 0)      expBit = 1'b0;
         else if (bitNo == 9) expBit = 1'b1;
         else                 expBit = b[bitNo-1];
         checkVal(tag, 32'(oTx), 32'(expBit));
         checkVal({tag, "_busy"}, 32'(oBusy), 1);
         tick();
      end
   endtask

   initial begin
      Reset        = 1'b1;
      iWriteEnable = 1'b0;
      iData        = 8'h00;

      // asynchronous reset, no clock edge yet
      #1 Reset = 1'b0;
      #2;
      checkVal("rst_tx",    32'(oTx),       1);
      checkVal("rst_count", 32'(oCount),    0);
      checkVal("rst_full",  32'(oFull),     0);
      checkVal("rst_ovf",   32'(oOverflow), 0);
      checkVal("rst_busy",  32'(oBusy),     0);
      @(negedge Clock);
      Reset = 1'b1;
      tick();

      // idle line
      for (int i = 0; i < 1000; i++) begin
         checkVal("idle_tx",   32'(oTx),   1);
         checkVal("idle_busy", 32'(oBusy), 0);
         tick();
      end

      // single byte
      iWriteEnable = 1'b1;
      iData        = 8'hA5;
      tick();
      iWriteEnable = 1'b0;
      checkVal("single_cnt_k", 32'(oCount), 1);
      checkVal("single_tx_k",  32'(oTx),    1);
      tick();
      checkFrame(8'hA5, "single");
      checkVal("single_busy_end", 32'(oBusy),  0);
      checkVal("single_tx_end",   32'(oTx),    1);
      checkVal("single_cnt_end",  32'(oCount), 0);

      // back-to-back frames
      peakCount = 0;
      fork
         begin
            iWriteEnable = 1'b1;
            iData = 8'h00; tick();
            iData = 8'hFF; tick();
            iData = 8'h55; tick();
            iWriteEnable = 1'b0;
         end
         begin
            tick();
            tick();
            checkFrame(8'h00, "b2b_0");
            checkFrame(8'hFF, "b2b_1");
            checkFrame(8'h55, "b2b_2");
         end
      join
      checkVal("b2b_busy_end", 32'(oBusy), 0);
      checkVal("b2b_peak",     32'(peakCount), 2);

      // overflow
      peakCount = 0;
      fork
         begin
            iWriteEnable = 1'b1;
            for (int i = 0; i < 6; i++) begin
               iData = ovfBytes[i];
               tick();
            end
            iWriteEnable = 1'b0;
         end
         begin
            repeat (5) tick();
            checkVal("ovf_cnt_k4",  32'(oCount),    4);
            checkVal("ovf_full_k4", 32'(oFull),     1);
            checkVal("ovf_flag_k4", 32'(oOverflow), 0);
            tick();
            checkVal("ovf_cnt_k5",  32'(oCount),    4);
            checkVal("ovf_flag_k5", 32'(oOverflow), 1);
         end
         begin
            tick();
            checkVal("ovf_cnt_k", 32'(oCount), 1);
            tick();
            checkVal("ovf_cnt_k1", 32'(oCount), 1);
            for (int i = 0; i < 5; i++) checkFrame(ovfBytes[i], "ovf_frame");
         end
      join
      checkVal("ovf_busy_end", 32'(oBusy),     0);
      checkVal("ovf_tx_end",   32'(oTx),       1);
      checkVal("ovf_sticky",   32'(oOverflow), 1);
      checkVal("ovf_peak",     32'(peakCount), 4);

      // push on the same edge as the STOP-to-START pop
      fork
         begin
            iWriteEnable = 1'b1;
            iData = 8'hC3; tick();
            iData = 8'h81; tick();
            iWriteEnable = 1'b0;
            repeat (39) tick();
            iWriteEnable = 1'b1;
            iData = 8'h5A; tick();
            iWriteEnable = 1'b0;
         end
         begin
            tick();
            tick();
            checkFrame(8'hC3, "sim_0");
            checkVal("sim_cnt", 32'(oCount), 1);
            checkFrame(8'h81, "sim_1");
            checkFrame(8'h5A, "sim_2");
         end
      join
      checkVal("sim_busy_end", 32'(oBusy), 0);
      checkVal("sim_ovf_held", 32'(oOverflow), 1);

      // reset during data bit 3
      iWriteEnable = 1'b1;
      iData = 8'h96; tick();
      iData = 8'h77; tick();
      iWriteEnable = 1'b0;
      repeat (17) tick();
      checkVal("mid_tx_bit3", 32'(oTx),    0);
      checkVal("mid_cnt_pre", 32'(oCount), 1);
      #2 Reset = 1'b0;
      #1;
      checkVal("mid_rst_tx",   32'(oTx),       1);
      checkVal("mid_rst_cnt",  32'(oCount),    0);
      checkVal("mid_rst_ovf",  32'(oOverflow), 0);
      checkVal("mid_rst_busy", 32'(oBusy),     0);
      @(negedge Clock);
      @(negedge Clock);
      Reset        = 1'b1;
      iWriteEnable = 1'b1;
      iData        = 8'h3C;
      tick();
      iWriteEnable = 1'b0;
      checkVal("post_rst_cnt", 32'(oCount), 1);
      tick();
      checkFrame(8'h3C, "post_rst");
      checkVal("post_rst_busy", 32'(oBusy),  0);
      checkVal("post_rst_tx",   32'(oTx),    1);
      checkVal("post_rst_cnt0", 32'(oCount), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
